// File: rtl/host_word_packer_if.sv
// Host word stream in, packed instruction / IO-input beats and config registers out.
// slave is the packer side, master is the host/top side that drives the stream and beat readies.
interface host_word_packer_if #(
  parameter int WORD_W     = 16,
  parameter int INSN_WORDS = 3,
  parameter int IO_WORDS   = 4,
  parameter int PROC_W     = 6
);
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [WORD_W-1:0]            in_word_i;
  logic                         insns_valid_o;
  logic                         insns_ready_i;
  logic [INSN_WORDS*WORD_W-1:0] insns_bits_o;
  logic                         io_i_valid_o;
  logic                         io_i_ready_i;
  logic [IO_WORDS*WORD_W-1:0]   io_i_bits_o;
  logic [WORD_W-1:0]            host_steps_o;
  logic [PROC_W-1:0]            used_procs_o;
  logic                         cfg_update_o;
  logic                         busy_o;
  logic                         err_o;

  modport slave (
    input  in_valid_i, in_word_i, insns_ready_i, io_i_ready_i,
    output in_ready_o, insns_valid_o, insns_bits_o, io_i_valid_o, io_i_bits_o,
    output host_steps_o, used_procs_o, cfg_update_o, busy_o, err_o
  );

  modport master (
    output in_valid_i, in_word_i, insns_ready_i, io_i_ready_i,
    input  in_ready_o, insns_valid_o, insns_bits_o, io_i_valid_o, io_i_bits_o,
    input  host_steps_o, used_procs_o, cfg_update_o, busy_o, err_o
  );
endinterface

// File: rtl/host_word_packer.sv
// Packs the 16-bit host word stream into 3-word instruction beats, 4-word IO-input beats
// and a host_steps/used_procs config write; illegal headers set a sticky error and drop payload.
module host_word_packer #(
  parameter int WORD_W     = 16,
  parameter int INSN_WORDS = 3,
  parameter int IO_WORDS   = 4,
  parameter int CNT_W      = WORD_W - 2,
  parameter int PROC_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  host_word_packer_if.slave bus
);

  localparam int MAX_WORDS = (IO_WORDS > INSN_WORDS) ? IO_WORDS : INSN_WORDS;
  localparam int IDX_W     = $clog2(MAX_WORDS);
  localparam logic [IDX_W-1:0] INSN_LAST = IDX_W'(INSN_WORDS - 1);
  localparam logic [IDX_W-1:0] IO_LAST   = IDX_W'(IO_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INSN = 3'd1,
    ST_IO   = 3'd2,
    ST_CFG  = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [(MAX_WORDS-1)*WORD_W-1:0] asm_q, asm_d;
  logic [INSN_WORDS*WORD_W-1:0]    insns_bits_q, insns_bits_d;
  logic                            insns_valid_q, insns_valid_d;
  logic [IO_WORDS*WORD_W-1:0]      io_bits_q, io_bits_d;
  logic                            io_valid_q, io_valid_d;
  logic [WORD_W-1:0]               steps_q, steps_d;
  logic [PROC_W-1:0]               procs_q, procs_d;
  logic [WORD_W-1:0]               stage_q, stage_d;
  logic                            cfg_upd_q, cfg_upd_d;
  logic                            err_q, err_d;
  logic                            alive_q;

  logic                            in_ready_s;
  logic                            fire_s;
  logic [1:0]                      cmd_s;
  logic [CNT_W-1:0]                n_s;

  assign cmd_s  = bus.in_word_i[WORD_W-1 -: 2];
  assign n_s    = bus.in_word_i[CNT_W-1:0];
  assign fire_s = bus.in_valid_i & in_ready_s;

  // Input acceptance: the last word of a beat waits until its output buffer is free.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_CFG, ST_DROP: in_ready_s = alive_q;
      ST_INSN: begin
        if (idx_q == INSN_LAST) in_ready_s = !insns_valid_q || bus.insns_ready_i;
        else                    in_ready_s = 1'b1;
      end
      ST_IO: begin
        if (idx_q == IO_LAST) in_ready_s = !io_valid_q || bus.io_i_ready_i;
        else                  in_ready_s = 1'b1;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Next-state and datapath updates for the packing FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    asm_d         = asm_q;
    insns_bits_d  = insns_bits_q;
    insns_valid_d = insns_valid_q & ~bus.insns_ready_i;
    io_bits_d     = io_bits_q;
    io_valid_d    = io_valid_q & ~bus.io_i_ready_i;
    steps_d       = steps_q;
    procs_d       = procs_q;
    stage_d       = stage_q;
    cfg_upd_d     = 1'b0;
    err_d         = err_q;

    // Non-final words of a beat land in the assembly slots indexed by idx_q.
    if (fire_s && (state_q == ST_INSN || state_q == ST_IO)) begin
      for (int k = 0; k < MAX_WORDS - 1; k++) begin
        if (idx_q == IDX_W'(k)) asm_d[k*WORD_W +: WORD_W] = bus.in_word_i;
        else                    asm_d[k*WORD_W +: WORD_W] = asm_q[k*WORD_W +: WORD_W];
      end
    end else begin
      asm_d = asm_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fire_s) begin
          idx_d = {IDX_W{1'b0}};
          case (cmd_s)
            2'b00: begin
              cnt_d = n_s;
              if (n_s != {CNT_W{1'b0}}) state_d = ST_INSN;
              else                      state_d = ST_IDLE;
            end
            2'b01: begin
              cnt_d = n_s;
              if (n_s != {CNT_W{1'b0}}) state_d = ST_IO;
              else                      state_d = ST_IDLE;
            end
            2'b10: state_d = ST_CFG;
            2'b11: begin
              err_d = 1'b1;
              cnt_d = n_s;
              if (n_s != {CNT_W{1'b0}}) state_d = ST_DROP;
              else                      state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INSN: begin
        if (fire_s && idx_q == INSN_LAST) begin
          insns_bits_d  = {bus.in_word_i, asm_q[(INSN_WORDS-1)*WORD_W-1:0]};
          insns_valid_d = 1'b1;
          idx_d         = {IDX_W{1'b0}};
          cnt_d         = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
          else                    state_d = ST_INSN;
        end else if (fire_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      ST_IO: begin
        if (fire_s && idx_q == IO_LAST) begin
          io_bits_d  = {bus.in_word_i, asm_q[(IO_WORDS-1)*WORD_W-1:0]};
          io_valid_d = 1'b1;
          idx_d      = {IDX_W{1'b0}};
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
          else                    state_d = ST_IO;
        end else if (fire_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      ST_CFG: begin
        // host_steps and used_procs commit together once word1 arrives.
        if (fire_s && idx_q == {IDX_W{1'b0}}) begin
          stage_d = bus.in_word_i;
          idx_d   = IDX_W'(1);
        end else if (fire_s) begin
          steps_d   = stage_q;
          procs_d   = bus.in_word_i[PROC_W-1:0];
          cfg_upd_d = 1'b1;
          idx_d     = {IDX_W{1'b0}};
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_CFG;
        end
      end
      ST_DROP: begin
        if (fire_s) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
          else                    state_d = ST_DROP;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; alive_q keeps in_ready low until the first clock after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      asm_q         <= '0;
      insns_bits_q  <= '0;
      insns_valid_q <= 1'b0;
      io_bits_q     <= '0;
      io_valid_q    <= 1'b0;
      steps_q       <= {WORD_W{1'b0}};
      procs_q       <= {PROC_W{1'b0}};
      stage_q       <= {WORD_W{1'b0}};
      cfg_upd_q     <= 1'b0;
      err_q         <= 1'b0;
      alive_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      insns_bits_q  <= insns_bits_d;
      insns_valid_q <= insns_valid_d;
      io_bits_q     <= io_bits_d;
      io_valid_q    <= io_valid_d;
      steps_q       <= steps_d;
      procs_q       <= procs_d;
      stage_q       <= stage_d;
      cfg_upd_q     <= cfg_upd_d;
      err_q         <= err_d;
      alive_q       <= 1'b1;
    end
  end

  assign bus.in_ready_o    = in_ready_s;
  assign bus.insns_valid_o = insns_valid_q;
  assign bus.insns_bits_o  = insns_bits_q;
  assign bus.io_i_valid_o  = io_valid_q;
  assign bus.io_i_bits_o   = io_bits_q;
  assign bus.host_steps_o  = steps_q;
  assign bus.used_procs_o  = procs_q;
  assign bus.cfg_update_o  = cfg_upd_q;
  assign bus.err_o         = err_q;
  assign bus.busy_o        = (state_q != ST_IDLE) | insns_valid_q | io_valid_q;

endmodule
